// File: rtl/ctrl_pkg.sv
// Shared encodings and the control bundle carried down the MIPS control pipeline.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       bne;
        logic       memwrite;
        logic       memread;
        logic       memtoreg;
        logic       jump;
        logic       link;
        logic [3:0] aluctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder producing the control bundle for the ID stage.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int EXT_OPS = 1
) (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       ill,
    output logic       uses_rt
);

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        ill     = 1'b0;
        uses_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                uses_rt       = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.aluctrl = ALU_ADD;
                    FN_SUB:  ctrl.aluctrl = ALU_SUB;
                    FN_AND:  ctrl.aluctrl = ALU_AND;
                    FN_OR:   ctrl.aluctrl = ALU_OR;
                    FN_SLT:  ctrl.aluctrl = ALU_SLT;
                    default: ill = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.aluctrl  = ALU_ADD;
            end
            OP_SW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.aluctrl  = ALU_ADD;
                uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch  = 1'b1;
                ctrl.aluctrl = ALU_SUB;
                uses_rt      = 1'b1;
            end
            OP_ADDI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluctrl  = ALU_ADD;
            end
            OP_J: begin
                ctrl.jump    = 1'b1;
                ctrl.aluctrl = ALU_AND;
            end
            OP_ANDI, OP_ORI, OP_SLTI: begin
                if (EXT_OPS != 0) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.aluctrl  = (opcode == OP_ANDI) ? ALU_AND :
                                    (opcode == OP_ORI)  ? ALU_OR  : ALU_SLT;
                end else begin
                    ill = 1'b1;
                end
            end
            OP_BNE: begin
                if (EXT_OPS != 0) begin
                    ctrl.branch  = 1'b1;
                    ctrl.bne     = 1'b1;
                    ctrl.aluctrl = ALU_SUB;
                    uses_rt      = 1'b1;
                end else begin
                    ill = 1'b1;
                end
            end
            OP_JAL: begin
                if (EXT_OPS != 0) begin
                    ctrl.jump     = 1'b1;
                    ctrl.link     = 1'b1;
                    ctrl.regwrite = 1'b1;
                end else begin
                    ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        // An illegal instruction must look exactly like a bubble downstream.
        if (ill) begin
            ctrl    = CTRL_BUBBLE;
            uses_rt = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined MIPS control: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use hazard detection, branch/jump flush and EX-stage forwarding selects.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int RA_W      = 5,
    parameter int EXT_OPS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [5:0]           id_opcode,
    input  logic [5:0]           id_funct,
    input  logic [RA_W-1:0]      id_rs,
    input  logic [RA_W-1:0]      id_rt,
    input  logic [RA_W-1:0]      id_rd,
    input  logic                 ex_zero,
    output logic [ALUCTRL_W-1:0] ex_aluctrl,
    output logic                 ex_alusrc,
    output logic                 ex_take,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 mem_memwrite,
    output logic                 mem_memread,
    output logic                 wb_regwrite,
    output logic                 wb_memtoreg,
    output logic                 wb_link,
    output logic [RA_W-1:0]      wb_dst,
    output logic                 id_jump,
    output logic                 stall,
    output logic                 flush_ifid,
    output logic                 ill_op
);

    localparam logic [RA_W-1:0] RA_LINK = RA_W'(31);
    localparam logic [RA_W-1:0] RA_ZERO = '0;

    ctrl_t           dec_ctrl;
    logic            dec_ill;
    logic            dec_uses_rt;
    logic            id_live;
    logic            load_use;
    logic            bubble;
    logic [RA_W-1:0] dec_dst;

    // ID/EX stage
    logic            vld_p0, regwrite_p0, alusrc_p0, branch_p0, bne_p0;
    logic            memwrite_p0, memread_p0, memtoreg_p0, link_p0;
    logic [3:0]      aluctrl_p0;
    logic [RA_W-1:0] rs_p0, rt_p0, dst_p0;
    // EX/MEM stage
    logic            vld_p1, regwrite_p1, memwrite_p1, memread_p1, memtoreg_p1, link_p1;
    logic [RA_W-1:0] dst_p1;
    // MEM/WB stage
    logic            vld_p2, regwrite_p2, memtoreg_p2, link_p2;
    logic [RA_W-1:0] dst_p2;

    ctrl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
        .opcode  (id_opcode),
        .funct   (id_funct),
        .ctrl    (dec_ctrl),
        .ill     (dec_ill),
        .uses_rt (dec_uses_rt)
    );

    // ID-facing outputs are masked while reset is held so nothing leaks out.
    assign id_live = id_valid & rst_n;
    assign dec_dst = dec_ctrl.link   ? RA_LINK :
                     dec_ctrl.regdst ? id_rd   : id_rt;

    assign ex_take  = branch_p0 & (ex_zero ^ bne_p0);
    assign load_use = memread_p0 & (dst_p0 != RA_ZERO) & id_live & ~dec_ill & ~dec_ctrl.jump
                    & ((dst_p0 == id_rs) | (dec_uses_rt & (dst_p0 == id_rt)));
    assign stall      = load_use & ~ex_take;
    assign id_jump    = id_live & ~dec_ill & dec_ctrl.jump & ~ex_take;
    assign flush_ifid = ex_take | id_jump;
    assign ill_op     = id_live & dec_ill;
    assign bubble     = ~id_live | dec_ill | ex_take | load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0      <= 1'b0;
            regwrite_p0 <= 1'b0;
            alusrc_p0   <= 1'b0;
            branch_p0   <= 1'b0;
            bne_p0      <= 1'b0;
            memwrite_p0 <= 1'b0;
            memread_p0  <= 1'b0;
            memtoreg_p0 <= 1'b0;
            link_p0     <= 1'b0;
            aluctrl_p0  <= '0;
            rs_p0       <= '0;
            rt_p0       <= '0;
            dst_p0      <= '0;
        end else if (bubble) begin
            vld_p0      <= 1'b0;
            regwrite_p0 <= 1'b0;
            alusrc_p0   <= 1'b0;
            branch_p0   <= 1'b0;
            bne_p0      <= 1'b0;
            memwrite_p0 <= 1'b0;
            memread_p0  <= 1'b0;
            memtoreg_p0 <= 1'b0;
            link_p0     <= 1'b0;
            aluctrl_p0  <= '0;
            rs_p0       <= '0;
            rt_p0       <= '0;
            dst_p0      <= '0;
        end else begin
            vld_p0      <= 1'b1;
            regwrite_p0 <= dec_ctrl.regwrite;
            alusrc_p0   <= dec_ctrl.alusrc;
            branch_p0   <= dec_ctrl.branch;
            bne_p0      <= dec_ctrl.bne;
            memwrite_p0 <= dec_ctrl.memwrite;
            memread_p0  <= dec_ctrl.memread;
            memtoreg_p0 <= dec_ctrl.memtoreg;
            link_p0     <= dec_ctrl.link;
            aluctrl_p0  <= dec_ctrl.aluctrl;
            rs_p0       <= id_rs;
            rt_p0       <= id_rt;
            dst_p0      <= dec_dst;
        end
    end

    // EX/MEM and MEM/WB advance every cycle, even during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            memwrite_p1 <= 1'b0;
            memread_p1  <= 1'b0;
            memtoreg_p1 <= 1'b0;
            link_p1     <= 1'b0;
            dst_p1      <= '0;
            vld_p2      <= 1'b0;
            regwrite_p2 <= 1'b0;
            memtoreg_p2 <= 1'b0;
            link_p2     <= 1'b0;
            dst_p2      <= '0;
        end else begin
            vld_p1      <= vld_p0;
            regwrite_p1 <= regwrite_p0;
            memwrite_p1 <= memwrite_p0;
            memread_p1  <= memread_p0;
            memtoreg_p1 <= memtoreg_p0;
            link_p1     <= link_p0;
            dst_p1      <= dst_p0;
            vld_p2      <= vld_p1;
            regwrite_p2 <= regwrite_p1;
            memtoreg_p2 <= memtoreg_p1;
            link_p2     <= link_p1;
            dst_p2      <= dst_p1;
        end
    end

    // EX/MEM wins over MEM/WB because it holds the younger result.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (vld_p1 && regwrite_p1 && (dst_p1 != RA_ZERO) && (dst_p1 == rs_p0))
            fwd_a = 2'b10;
        else if (vld_p2 && regwrite_p2 && (dst_p2 != RA_ZERO) && (dst_p2 == rs_p0))
            fwd_a = 2'b01;
        if (vld_p1 && regwrite_p1 && (dst_p1 != RA_ZERO) && (dst_p1 == rt_p0))
            fwd_b = 2'b10;
        else if (vld_p2 && regwrite_p2 && (dst_p2 != RA_ZERO) && (dst_p2 == rt_p0))
            fwd_b = 2'b01;
    end

    assign ex_aluctrl   = ALUCTRL_W'(aluctrl_p0);
    assign ex_alusrc    = alusrc_p0;
    assign mem_memwrite = memwrite_p1;
    assign mem_memread  = memread_p1;
    assign wb_regwrite  = vld_p2 & regwrite_p2;
    assign wb_memtoreg  = memtoreg_p2;
    assign wb_link      = link_p2;
    assign wb_dst       = dst_p2;

endmodule
